// File: rtl/axi_lite_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regfile_slave
// Purpose  : AXI4-Lite slave that terminates all five channels into a register
//            file of NUM_REGS words of DATA_W bits. AW and W are captured into
//            independent one-entry holding registers. A write commits once both
//            holding registers are full and no B response is outstanding. One
//            read can be outstanding at a time.
// Ports    : ACLK, ARESETN       - clock, asynchronous active-low reset
//            AW*/W*/B*           - write address, data and response channels
//            AR*/R*              - read address and data channels
//            regs_out            - flat register contents, reg i at
//                                  [i*DATA_W +: DATA_W]
//            wr_pulse            - one-cycle strobe on an in-range write commit
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regfile_slave #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic                       WVALID,
  output logic                       WREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [DATA_W/8-1:0]        WSTRB,
  output logic                       BVALID,
  input  logic                       BREADY,
  output logic [1:0]                 BRESP,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_pulse
);

  localparam int         c_nbytes = DATA_W / 8;
  localparam int         c_lsb    = $clog2(c_nbytes);
  localparam int         c_idx_w  = $clog2(NUM_REGS);
  localparam logic [1:0] c_okay   = 2'b00;
  localparam logic [1:0] c_slverr = 2'b10;

  generate
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
      $error("axi_lite_regfile_slave: DATA_W must be 32 or 64");
    end
    if (NUM_REGS < 2) begin : g_bad_num_regs
      $error("axi_lite_regfile_slave: NUM_REGS must be at least 2");
    end
  endgenerate

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic                r_aw_held;
  logic                r_aw_err;
  logic [c_idx_w-1:0]  r_aw_idx;
  logic                r_w_held;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_nbytes-1:0] r_wstrb;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_wr_pulse;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;

  // Word index is the byte address with the in-word offset dropped; the full
  // shifted word is kept for the range check so high address bits count.
  logic [ADDR_W-1:0] w_aw_word;
  logic [ADDR_W-1:0] w_ar_word;
  logic              w_aw_err;
  logic              w_ar_err;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_ar_hs;
  logic              w_commit;

  assign w_aw_word = AWADDR >> c_lsb;
  assign w_ar_word = ARADDR >> c_lsb;
  assign w_aw_err  = (w_aw_word >= ADDR_W'(NUM_REGS));
  assign w_ar_err  = (w_ar_word >= ADDR_W'(NUM_REGS));
  assign w_aw_hs   = AWVALID && !r_aw_held;
  assign w_w_hs    = WVALID && !r_w_held;
  assign w_ar_hs   = ARVALID && !r_rvalid;
  // Commit only when no response is pending, so a stalled B never gets
  // overwritten by a newer write.
  assign w_commit  = r_aw_held && r_w_held && !r_bvalid;

  // Holding registers. Capture and commit are mutually exclusive because a
  // full holding register deasserts its READY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_held <= 1'b0;
      r_aw_err  <= 1'b0;
      r_aw_idx  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_err  <= w_aw_err;
        r_aw_idx  <= w_aw_word[c_idx_w-1:0];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= WDATA;
        r_wstrb  <= WSTRB;
      end
    end
  end

  // Write response and commit strobe.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_bvalid   <= 1'b0;
      r_bresp    <= c_okay;
      r_wr_pulse <= 1'b0;
    end else begin
      r_wr_pulse <= 1'b0;
      if (w_commit) begin
        r_bvalid   <= 1'b1;
        r_bresp    <= r_aw_err ? c_slverr : c_okay;
        r_wr_pulse <= !r_aw_err;
      end else if (r_bvalid && BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Register file with byte-lane masking.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (w_commit && !r_aw_err) begin
      for (int b = 0; b < c_nbytes; b++) begin
        if (r_wstrb[b]) begin
          r_regs[r_aw_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read path. RDATA samples the array before any same-edge commit lands,
  // so a colliding read returns the pre-write value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= c_okay;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      if (w_ar_err) begin
        r_rdata <= '0;
        r_rresp <= c_slverr;
      end else begin
        r_rdata <= r_regs[w_ar_word[c_idx_w-1:0]];
        r_rresp <= c_okay;
      end
    end else if (r_rvalid && RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
      assign regs_out[i*DATA_W +: DATA_W] = r_regs[i];
    end
  endgenerate

  assign AWREADY  = !r_aw_held;
  assign WREADY   = !r_w_held;
  assign ARREADY  = !r_rvalid;
  assign BVALID   = r_bvalid;
  assign BRESP    = r_bresp;
  assign RVALID   = r_rvalid;
  assign RDATA    = r_rdata;
  assign RRESP    = r_rresp;
  assign wr_pulse = r_wr_pulse;

endmodule
`default_nettype wire

// File: doc/axi_lite_regfile_slave.md
Name: axi_lite_regfile_slave

Overview:
Parametrised AXI4-Lite slave that terminates all five AXI channels into a register file of NUM_REGS words of DATA_W bits. AW and W are accepted independently and fully handshaked. WSTRB byte-lane masking is applied. Out-of-range accesses return SLVERR. It replaces the fixed-width slave in the master/slave top, and exposes every register on a flat output bus for downstream logic.

Parameters:
ADDR_W, 32, address width of AWADDR/ARADDR
DATA_W, 32, data width; only 32 or 64 are legal
NUM_REGS, 16, number of registers (≥2)
RESET_VAL, 0, reset value of every register (DATA_W bits)

Ports:
ACLK  in  1  clock, all logic on the rising edge
ARESETN  in  1  asynchronous active-low reset
AWVALID/AWREADY  in/out  1/1  write address handshake
AWADDR  in  ADDR_W  write byte address
WVALID/WREADY  in/out  1/1  write data handshake
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte-lane enables
BVALID/BREADY  out/in  1/1  write response handshake
BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
ARVALID/ARREADY  in/out  1/1  read address handshake
ARADDR  in  ADDR_W  read byte address
RVALID/RREADY  out/in  1/1  read data handshake
RDATA  out  DATA_W  read data
RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
regs_out  out  NUM_REGS*DATA_W  flat register contents; reg i is at bits [i*DATA_W +: DATA_W]
wr_pulse  out  1  one-cycle strobe when a write commits to the register file

Behaviour:
- Reset (ARESETN low, asynchronous): every register takes RESET_VAL. BVALID, RVALID and wr_pulse go to 0. BRESP, RRESP and RDATA go to 0. AW/W holding registers are cleared. AWREADY, WREADY and ARREADY go to 1 (deasserted during reset, asserted on the first edge after release is also acceptable? No: they are held at 1 from reset).
- Reset mid-transaction aborts it. No response is issued for an aborted transaction.
- Register index = addr >> log2(DATA_W/8). Low address bits are ignored, so unaligned addresses are treated as aligned. Index ≥ NUM_REGS is out of range.
- Write path, one-entry AW holding register and one-entry W holding register:
  - AWREADY = !aw_held. WREADY = !w_held. Each channel is captured on its own handshake, in either order or in the same cycle.
  - Commit happens on the cycle after both are held and BVALID=0.
  - Commit action: for each byte lane b with WSTRB[b]=1, reg[idx] byte b takes WDATA byte b.
  - On commit: wr_pulse=1 for that cycle, BVALID=1, BRESP=OKAY. Both holding registers are cleared.
  - Out-of-range commit: no register changes, wr_pulse stays 0, BRESP=SLVERR.
  - WSTRB=0 in range: no register change, wr_pulse=1, BRESP=OKAY.
  - BVALID and BRESP stay stable until BREADY. BVALID drops the cycle after the BVALID&BREADY handshake.
  - While BVALID=1, new AW/W may be captured into empty holding registers, but they do not commit until the response completes.
- Write latency: 2 cycles from simultaneous AW+W handshake to BVALID.
- Read path, single outstanding read:
  - ARREADY = !RVALID.
  - On the ARVALID&ARREADY handshake, the next edge sets RVALID=1. RDATA = reg[idx] and RRESP=OKAY, or RDATA=0 and RRESP=SLVERR when out of range.
  - RVALID, RDATA and RRESP stay stable until RREADY. RVALID clears on handshake.
  - Read latency is 1 cycle.
- Read and write commit to the same register on the same edge: the read returns the pre-write value.
- regs_out is always the current register state. There is no combinational path from any input to any output.
- DATA_W other than 32 or 64 is a static error: elaboration fails.

Test Plan:
- Reset: hold ARESETN=0 for 3 cycles, release, read reg 0..15 -> each returns RVALID=1 with RDATA=0, RRESP=00, 1 cycle after each AR handshake.
- Full write/readback: AW+W same cycle, AWADDR=0x08, WDATA=0xDEADBEEF, WSTRB=4'hF -> BVALID 2 cycles later with BRESP=00; wr_pulse for 1 cycle; regs_out[95:64]=0xDEADBEEF; reading 0x08 returns 0xDEADBEEF.
- Byte strobe and ordering: W sent (0x11223344, WSTRB=4'b0101) 3 cycles before AW to 0x08, which holds 0xDEADBEEF -> register becomes 0xDE22BE44 and BRESP=00.
- Out of range: write 0xFFFF_FFFF to 0x40 with NUM_REGS=16 -> BRESP=10, no register change, wr_pulse=0. Read 0x40 -> RDATA=0, RRESP=10.
- Backpressure: hold BREADY=0 for 5 cycles, and RREADY=0 for 5 cycles on a pending read -> BVALID/BRESP and RVALID/RDATA stay stable, ARREADY=0, and a second AW is captured but not committed until B completes.
- Async reset mid-write: AW captured, W not yet sent, ARESETN pulsed low between clock edges -> holding registers cleared, no BVALID, registers at RESET_VAL.
